// File: rtl/klingon_scan_display.sv
// Multiplexed Klingon-glyph display driver: holding register, prescaled digit scan
// with dead time, optional leading-zero blanking and a frame-start pulse.
module klingon_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000,
  parameter int DEAD       = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] D,
  input  logic                    load,
  input  logic                    lzb,
  output logic [6:0]              Y,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] h;
  logic                    dead;
  logic                    lead_zero;
  logic                    blank_lz;
  logic [3:0]              code;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b1000000;
      4'd2:    glyph = 7'b1000001;
      4'd3:    glyph = 7'b1001001;
      4'd4:    glyph = 7'b0100011;
      4'd5:    glyph = 7'b0011101;
      4'd6:    glyph = 7'b0100101;
      4'd7:    glyph = 7'b0010011;
      4'd8:    glyph = 7'b0110110;
      4'd9:    glyph = 7'b0110111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Split on DEAD so a zero dead time never produces a constant unsigned compare.
  generate
    if (DEAD == 0) begin : g_no_dead
      always_comb dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
      always_comb dead = (cnt < DEAD_C);
    end
  endgenerate

  always_comb begin
    lead_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) >= idx) && (h[4*k +: 4] != 4'd0)) lead_zero = 1'b0;
    end
    code     = h[{idx, 2'b00} +: 4];
    blank_lz = lzb && (idx != '0) && lead_zero;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      idx   <= '0;
      h     <= '0;
      frame <= 1'b0;
      AN    <= '1;
      Y     <= '0;
    end else begin
      if (load) h <= D;

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      frame <= (cnt == CNT_LAST) && (idx == IDX_LAST);

      if (dead) begin
        AN <= '1;
        Y  <= '0;
      end else begin
        AN <= ~(NUM_DIGITS'(1) << idx);
        Y  <= blank_lz ? '0 : glyph(code);
      end
    end
  end

endmodule

// File: tb/tb_klingon_scan_display.sv
// Directed bench for klingon_scan_display: NUM_DIGITS=4, PRESCALE=4, with DEAD=1
// and a second DEAD=0 instance sharing the same stimulus.
module tb_klingon_scan_display;

  localparam int N = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic        lzb;
  logic [15:0] D;
  logic [6:0]  y, y_nd;
  logic [3:0]  an, an_nd;
  logic        frame, frame_nd;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned edges      = 0;

  always #5 clk = ~clk;

  klingon_scan_display #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .D(D), .load(load), .lzb(lzb),
    .Y(y), .AN(an), .frame(frame)
  );

  klingon_scan_display #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD(0)) u_nd (
    .clk(clk), .reset_n(reset_n), .D(D), .load(load), .lzb(lzb),
    .Y(y_nd), .AN(an_nd), .frame(frame_nd)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    edges++;
  endtask

  // Outputs after edge e reflect the (idx, cnt) that held before it.
  function automatic int unsigned slot_of(input int unsigned e);
    return ((e - 1) / 4) % 4;
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned e, input bit has_dead);
    if (e == 0) return 4'b1111;
    if (has_dead && ((e - 1) % 4 == 0)) return 4'b1111;
    return ~(4'b0001 << slot_of(e));
  endfunction

  function automatic logic exp_fr(input int unsigned e);
    return (e > 0) && ((e - 1) % 16 == 15);
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; load = 1'b1; lzb = 1'b0; D = 16'h4321;
    tick; tick;
    compared += 4;
    if (an !== 4'b1111) begin mismatched++; $display("FAIL reset_an got %b want 1111", an); end
    if (y !== 7'd0) begin mismatched++; $display("FAIL reset_y got %b want 0000000", y); end
    if (frame !== 1'b0) begin mismatched++; $display("FAIL reset_frame got %b want 0", frame); end
    if (an_nd !== 4'b1111) begin mismatched++; $display("FAIL reset_an_nd got %b want 1111", an_nd); end
    reset_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_scan;
    logic [6:0] ylut [4];
    logic [3:0] ea;
    logic [6:0] ey;
    ylut = '{7'b1000000, 7'b1000001, 7'b1001001, 7'b0100011};
    for (int t = 0; t < 32; t++) begin
      tick;
      if (edges == 1) load = 1'b0;
      ea = exp_an(edges, 1'b1);
      ey = (ea == 4'b1111) ? 7'd0 : ylut[slot_of(edges)];
      compared += 3;
      if (an !== ea) begin mismatched++; $display("FAIL scan_an e=%0d got %b want %b", edges, an, ea); end
      if (y !== ey) begin mismatched++; $display("FAIL scan_y e=%0d got %b want %b", edges, y, ey); end
      if (frame !== exp_fr(edges)) begin
        mismatched++; $display("FAIL scan_frame e=%0d got %b want %b", edges, frame, exp_fr(edges));
      end
    end
  endtask

  task automatic test_lzb_single;
    logic [6:0] ylut [4];
    logic [3:0] ea;
    logic [6:0] ey;
    D = 16'h0005; load = 1'b1; lzb = 1'b1;
    tick;
    load = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) ylut = '{7'b0011101, 7'd0, 7'd0, 7'd0};
      else begin
        lzb  = 1'b0;
        ylut = '{7'b0011101, 7'b1111110, 7'b1111110, 7'b1111110};
      end
      for (int t = 0; t < 16; t++) begin
        tick;
        ea = exp_an(edges, 1'b1);
        ey = (ea == 4'b1111) ? 7'd0 : ylut[slot_of(edges)];
        compared += 2;
        if (an !== ea) begin mismatched++; $display("FAIL lzb5_an p=%0d e=%0d got %b want %b", pass, edges, an, ea); end
        if (y !== ey) begin mismatched++; $display("FAIL lzb5_y p=%0d e=%0d got %b want %b", pass, edges, y, ey); end
      end
    end
  endtask

  task automatic test_lzb_invalid_code;
    logic [6:0] ylut [4];
    logic [3:0] ea;
    logic [6:0] ey;
    ylut = '{7'b1111110, 7'b1111110, 7'd0, 7'd0};
    D = 16'h0A00; load = 1'b1; lzb = 1'b1;
    tick;
    load = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick;
      ea = exp_an(edges, 1'b1);
      ey = (ea == 4'b1111) ? 7'd0 : ylut[slot_of(edges)];
      compared += 2;
      if (an !== ea) begin mismatched++; $display("FAIL lzbA_an e=%0d got %b want %b", edges, an, ea); end
      if (y !== ey) begin mismatched++; $display("FAIL lzbA_y e=%0d got %b want %b", edges, y, ey); end
    end
  endtask

  task automatic test_load_mid_slot;
    logic [6:0] ylut [4];
    logic [3:0] ea;
    logic [6:0] ey;
    ylut = '{7'b0100101, 7'b0010011, 7'b0110110, 7'b0110111};
    lzb = 1'b0;
    tick;
    while (edges % 16 != 1) tick;
    D = 16'h9876; load = 1'b1;
    tick;
    compared += 2;
    if (y !== 7'b1111110) begin mismatched++; $display("FAIL midload_old_y got %b want 1111110", y); end
    if (an !== 4'b1110) begin mismatched++; $display("FAIL midload_an got %b want 1110", an); end
    load = 1'b0; D = 16'h1234;
    tick;
    compared++;
    if (y !== 7'b0100101) begin mismatched++; $display("FAIL midload_new_y got %b want 0100101", y); end
    for (int t = 0; t < 16; t++) begin
      D = 16'($urandom);
      tick;
      ea = exp_an(edges, 1'b1);
      ey = (ea == 4'b1111) ? 7'd0 : ylut[slot_of(edges)];
      compared += 2;
      if (an !== ea) begin mismatched++; $display("FAIL hold_an e=%0d got %b want %b", edges, an, ea); end
      if (y !== ey) begin mismatched++; $display("FAIL hold_y e=%0d got %b want %b", edges, y, ey); end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] ea;
    logic [6:0] ey;
    while (edges % 16 != 0) tick;
    compared += 3;
    if (frame !== 1'b1) begin mismatched++; $display("FAIL prereset_frame got %b want 1", frame); end
    if (an !== 4'b0111) begin mismatched++; $display("FAIL prereset_an got %b want 0111", an); end
    if (y !== 7'b0110111) begin mismatched++; $display("FAIL prereset_y got %b want 0110111", y); end
    #2 reset_n = 1'b0;
    #1;
    compared += 5;
    if (an !== 4'b1111) begin mismatched++; $display("FAIL async_an got %b want 1111", an); end
    if (y !== 7'd0) begin mismatched++; $display("FAIL async_y got %b want 0000000", y); end
    if (frame !== 1'b0) begin mismatched++; $display("FAIL async_frame got %b want 0", frame); end
    if (an_nd !== 4'b1111) begin mismatched++; $display("FAIL async_an_nd got %b want 1111", an_nd); end
    if (y_nd !== 7'd0) begin mismatched++; $display("FAIL async_y_nd got %b want 0000000", y_nd); end
    tick; tick;
    reset_n = 1'b1;
    edges = 0;
    for (int t = 0; t < 16; t++) begin
      tick;
      ea = exp_an(edges, 1'b1);
      ey = (ea == 4'b1111) ? 7'd0 : 7'b1111110;
      compared += 3;
      if (an !== ea) begin mismatched++; $display("FAIL postrst_an e=%0d got %b want %b", edges, an, ea); end
      if (y !== ey) begin mismatched++; $display("FAIL postrst_y e=%0d got %b want %b", edges, y, ey); end
      if (frame !== exp_fr(edges)) begin
        mismatched++; $display("FAIL postrst_frame e=%0d got %b want %b", edges, frame, exp_fr(edges));
      end
    end
  endtask

  task automatic test_no_dead;
    int         low_cnt [4];
    logic [3:0] ea;
    low_cnt = '{0, 0, 0, 0};
    for (int t = 0; t < 16; t++) begin
      tick;
      ea = exp_an(edges, 1'b0);
      compared += 3;
      if (an_nd !== ea) begin mismatched++; $display("FAIL nodead_an e=%0d got %b want %b", edges, an_nd, ea); end
      if (y_nd !== 7'b1111110) begin mismatched++; $display("FAIL nodead_y e=%0d got %b want 1111110", edges, y_nd); end
      if (frame_nd !== exp_fr(edges)) begin
        mismatched++; $display("FAIL nodead_frame e=%0d got %b want %b", edges, frame_nd, exp_fr(edges));
      end
      for (int k = 0; k < 4; k++) if (an_nd[k] === 1'b0) low_cnt[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (low_cnt[k] != 4) begin
        mismatched++; $display("FAIL nodead_lowcount digit=%0d got %0d want 4", k, low_cnt[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_lzb_single;
    test_lzb_invalid_code;
    test_load_mid_slot;
    test_async_reset;
    test_no_dead;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
